request_encoder: RTL and testbench

- Sequential 4-to-2 (parameterisable N-to-log2N) encoder: the inverse of the team's address decoder.
- Captures request pulses on N one-hot-style input lines into a pending register, arbitrates among them, and emits one encoded address per valid/ready transfer.
- The encoded address is fed back to a decoder or a register-file select on the consumer side.

---
 rtl/request_encoder.sv | 179 +++++++++++++++++
 tb/tb_request_encoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/request_encoder.sv
// -----------------------------------------------------------------------------
// request_encoder
//
// Sequential N-to-log2(N) encoder, the inverse of the address decoder.
// Request pulses on the 'in' lines are collected into a pending register,
// one of them is chosen by an arbiter, and its index is presented on
// 'address' through a registered valid/ready output stage. The consumer
// feeds 'address' straight into a decoder or register-file select, so index
// i is encoded as plain binary i with address[0] as the LSB.
//
// Parameters
//   N   number of request lines (power of two, at least 2)
//   W   address width, equal to log2(N)
//   RR  arbitration mode: 0 = fixed priority (lowest index wins),
//                         1 = round-robin starting from a rotating pointer
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   enable   in   request capture enable; 'in' is ignored while low
//   in       in   N request lines, any number may be high in one cycle
//   valid    out  address holds an encoded request not yet accepted
//   address  out  W-bit encoded index of the granted request
//   ready    in   consumer accepts address when valid is also high
//   pending  out  requests captured but not yet granted
//   busy     out  combinational: any pending request or valid output
// -----------------------------------------------------------------------------
module request_encoder #(
    parameter int N  = 4,
    parameter int W  = 2,
    parameter bit RR = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [N-1:0] in,
    output logic         valid,
    output logic [W-1:0] address,
    input  logic         ready,
    output logic [N-1:0] pending,
    output logic         busy
);

    // -------------------------------------------------------------------------
    // State registers and their next-state values
    // -------------------------------------------------------------------------
    logic [N-1:0] pending_q, pending_d;
    logic         valid_q,   valid_d;
    logic [W-1:0] address_q, address_d;
    logic [W-1:0] ptr_q,     ptr_d;

    // -------------------------------------------------------------------------
    // Combinational working signals
    // -------------------------------------------------------------------------
    logic [N-1:0] reqEff;
    logic [N-1:0] cand;
    logic         haveCand;
    logic         load;
    logic [W-1:0] fixedIdx;
    logic [W-1:0] rrIdx;
    logic [W-1:0] rrProbe;
    logic [W-1:0] grantIdx;
    logic [N-1:0] grantMask;

    // -------------------------------------------------------------------------
    // Capture and load qualification.
    // The candidate set merges what is already pending with this cycle's
    // requests, so a repeated request for a pending index collapses into a
    // single grant. The output stage may take a new value whenever it is
    // empty or its current value is being accepted this cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        reqEff   = enable ? in : '0;
        cand     = pending_q | reqEff;
        haveCand = |cand;
        load     = !valid_q || ready;
    end

    // -------------------------------------------------------------------------
    // Fixed-priority pick: scanning from the top down and overwriting means
    // the last hit, i.e. the lowest set index, is the one that survives.
    // -------------------------------------------------------------------------
    always_comb begin
        fixedIdx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) begin
                fixedIdx = W'(i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Round-robin pick: probe indices ptr, ptr+1, ... in W-bit arithmetic.
    // Because N is a power of two, the W-bit sum wraps from N-1 back to 0
    // without an explicit modulo. Scanning offsets from the far end down to
    // zero leaves the nearest set index at or above ptr as the winner.
    // -------------------------------------------------------------------------
    always_comb begin
        rrIdx   = ptr_q;
        rrProbe = '0;
        for (int k = N - 1; k >= 0; k--) begin
            rrProbe = ptr_q + W'(k);
            if (cand[rrProbe]) begin
                rrIdx = rrProbe;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Grant selection and the one-hot mask used to retire the granted bit
    // from the pending set.
    // -------------------------------------------------------------------------
    always_comb begin
        grantIdx  = RR ? rrIdx : fixedIdx;
        grantMask = N'(1) << grantIdx;
    end

    // -------------------------------------------------------------------------
    // Next-state logic for the pending set, the output stage and the
    // round-robin pointer. Defaults hold everything; each branch only states
    // what changes.
    //
    // While stalled (valid high, ready low) the held address must stay
    // stable, but new requests still accumulate. A request for the very
    // index that is currently held goes back into pending and earns a second
    // grant later, since the held one has not been consumed yet.
    // -------------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q;
        valid_d   = valid_q;
        address_d = address_q;
        ptr_d     = ptr_q;

        if (load) begin
            if (haveCand) begin
                address_d = grantIdx;
                valid_d   = 1'b1;
                pending_d = cand & ~grantMask;
                ptr_d     = grantIdx + W'(1);
            end else begin
                valid_d   = 1'b0;
                pending_d = '0;
            end
        end else begin
            pending_d = cand;
        end
    end

    // -------------------------------------------------------------------------
    // State register with synchronous reset. Reset discards any held address
    // without it ever being accepted, and the request lines are ignored on
    // that edge because the reset branch takes precedence over capture.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            address_q <= '0;
            ptr_q     <= '0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            address_q <= address_d;
            ptr_q     <= ptr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. busy is derived combinationally from state so a consumer can
    // tell whether anything is left to drain.
    // -------------------------------------------------------------------------
    always_comb begin
        valid   = valid_q;
        address = address_q;
        pending = pending_q;
        busy    = (|pending_q) | valid_q;
    end

endmodule

// File: tb/tb_request_encoder.sv
// -----------------------------------------------------------------------------
// tb_request_encoder
//
// Directed testbench for request_encoder. Two instances share every input:
// dutF uses fixed priority and dutR uses round-robin. Each step drives the
// inputs, advances one rising edge and then samples the outputs 1 time unit
// later, comparing them against hand-computed values.
// -----------------------------------------------------------------------------
module tb_request_encoder;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] in;
    logic       ready;

    logic       validF;
    logic [1:0] addressF;
    logic [3:0] pendingF;
    logic       busyF;

    logic       validR;
    logic [1:0] addressR;
    logic [3:0] pendingR;
    logic       busyR;

    int checks;
    int errors;

    // -------------------------------------------------------------------------
    // Fixed-priority instance
    // -------------------------------------------------------------------------
    request_encoder #(.N(4), .W(2), .RR(1'b0)) dutF (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .in      (in),
        .valid   (validF),
        .address (addressF),
        .ready   (ready),
        .pending (pendingF),
        .busy    (busyF)
    );

    // -------------------------------------------------------------------------
    // Round-robin instance
    // -------------------------------------------------------------------------
    request_encoder #(.N(4), .W(2), .RR(1'b1)) dutR (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .in      (in),
        .valid   (validR),
        .address (addressR),
        .ready   (ready),
        .pending (pendingR),
        .busy    (busyR)
    );

    // -------------------------------------------------------------------------
    // 10-unit clock
    // -------------------------------------------------------------------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // -------------------------------------------------------------------------
    // Advance one rising edge and settle just past it before sampling
    // -------------------------------------------------------------------------
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Single comparison point with its own immediate assertion
    // -------------------------------------------------------------------------
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        logic [1:0] rrExpect;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        enable = 1'b1;
        in     = 4'b1111;
        ready  = 1'b1;

        // Reset held two cycles with every request line high
        applyStimulus();
        checkOutput("rst1_validF", 32'(validF), 32'd0);
        checkOutput("rst1_pendingF", 32'(pendingF), 32'd0);
        checkOutput("rst1_busyF", 32'(busyF), 32'd0);
        applyStimulus();
        checkOutput("rst2_validF", 32'(validF), 32'd0);
        checkOutput("rst2_pendingR", 32'(pendingR), 32'd0);
        checkOutput("rst2_busyR", 32'(busyR), 32'd0);

        // Idle after release
        reset = 1'b0;
        in    = 4'b0000;
        applyStimulus();
        checkOutput("idle_validF", 32'(validF), 32'd0);
        checkOutput("idle_pendingF", 32'(pendingF), 32'd0);
        checkOutput("idle_busyF", 32'(busyF), 32'd0);

        // Single request for index 2
        in = 4'b0100;
        applyStimulus();
        checkOutput("single_validF", 32'(validF), 32'd1);
        checkOutput("single_addressF", 32'(addressF), 32'd2);
        checkOutput("single_pendingF", 32'(pendingF), 32'd0);
        checkOutput("single_busyF", 32'(busyF), 32'd1);
        in = 4'b0000;
        applyStimulus();
        checkOutput("single_done_validF", 32'(validF), 32'd0);
        checkOutput("single_done_addressF", 32'(addressF), 32'd2);

        // Fixed-priority burst 1011 -> 0, 1, 3
        in = 4'b1011;
        applyStimulus();
        in = 4'b0000;
        checkOutput("burst0_addressF", 32'(addressF), 32'd0);
        checkOutput("burst0_pendingF", 32'(pendingF), 32'b1010);
        applyStimulus();
        checkOutput("burst1_addressF", 32'(addressF), 32'd1);
        checkOutput("burst1_pendingF", 32'(pendingF), 32'b1000);
        applyStimulus();
        checkOutput("burst2_addressF", 32'(addressF), 32'd3);
        checkOutput("burst2_validF", 32'(validF), 32'd1);
        checkOutput("burst2_pendingF", 32'(pendingF), 32'b0000);
        applyStimulus();
        checkOutput("burst_done_validF", 32'(validF), 32'd0);

        // Backpressure: address 0 held while index 3 accumulates
        ready = 1'b0;
        in    = 4'b0001;
        applyStimulus();
        in = 4'b0000;
        checkOutput("stall1_validF", 32'(validF), 32'd1);
        checkOutput("stall1_addressF", 32'(addressF), 32'd0);
        applyStimulus();
        checkOutput("stall2_addressF", 32'(addressF), 32'd0);
        checkOutput("stall2_pendingF", 32'(pendingF), 32'b0000);
        in = 4'b1000;
        applyStimulus();
        in = 4'b0000;
        checkOutput("stall3_addressF", 32'(addressF), 32'd0);
        checkOutput("stall3_pendingF", 32'(pendingF), 32'b1000);
        applyStimulus();
        applyStimulus();
        checkOutput("stall5_validF", 32'(validF), 32'd1);
        checkOutput("stall5_addressF", 32'(addressF), 32'd0);
        checkOutput("stall5_pendingF", 32'(pendingF), 32'b1000);
        checkOutput("stall5_busyF", 32'(busyF), 32'd1);
        ready = 1'b1;
        applyStimulus();
        checkOutput("release_addressF", 32'(addressF), 32'd3);
        checkOutput("release_validF", 32'(validF), 32'd1);
        checkOutput("release_pendingF", 32'(pendingF), 32'b0000);
        applyStimulus();
        checkOutput("release_done_validF", 32'(validF), 32'd0);

        // Round-robin fairness with all lines held high
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        in    = 4'b1111;
        for (int g = 0; g < 8; g++) begin
            applyStimulus();
            rrExpect = 2'(g);
            checkOutput($sformatf("rr%0d_addressR", g), 32'(addressR), 32'(rrExpect));
            checkOutput($sformatf("rr%0d_validR", g), 32'(validR), 32'd1);
        end
        in = 4'b0000;

        // Enable low: pending 0110 drains, the masked request for 0 is dropped
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        ready = 1'b0;
        in    = 4'b0001;
        applyStimulus();
        in = 4'b0110;
        applyStimulus();
        checkOutput("en_setup_pendingF", 32'(pendingF), 32'b0110);
        checkOutput("en_setup_pendingR", 32'(pendingR), 32'b0110);
        checkOutput("en_setup_addressF", 32'(addressF), 32'd0);
        enable = 1'b0;
        in     = 4'b0001;
        ready  = 1'b1;
        applyStimulus();
        checkOutput("en_g1_addressF", 32'(addressF), 32'd1);
        checkOutput("en_g1_addressR", 32'(addressR), 32'd1);
        checkOutput("en_g1_pendingF", 32'(pendingF), 32'b0100);
        applyStimulus();
        checkOutput("en_g2_addressF", 32'(addressF), 32'd2);
        checkOutput("en_g2_addressR", 32'(addressR), 32'd2);
        checkOutput("en_g2_pendingF", 32'(pendingF), 32'b0000);
        applyStimulus();
        checkOutput("en_done_validF", 32'(validF), 32'd0);
        checkOutput("en_done_validR", 32'(validR), 32'd0);
        checkOutput("en_done_busyF", 32'(busyF), 32'd0);

        // Same setup, then reset while stalled
        enable = 1'b1;
        ready  = 1'b0;
        in     = 4'b0001;
        applyStimulus();
        in = 4'b0110;
        applyStimulus();
        checkOutput("mid_setup_pendingR", 32'(pendingR), 32'b0110);
        checkOutput("mid_setup_validR", 32'(validR), 32'd1);
        in    = 4'b0000;
        reset = 1'b1;
        applyStimulus();
        checkOutput("mid_rst_validF", 32'(validF), 32'd0);
        checkOutput("mid_rst_pendingF", 32'(pendingF), 32'd0);
        checkOutput("mid_rst_validR", 32'(validR), 32'd0);
        checkOutput("mid_rst_pendingR", 32'(pendingR), 32'd0);
        checkOutput("mid_rst_busyR", 32'(busyR), 32'd0);

        // Round-robin pointer restarts at 0 after reset
        reset = 1'b0;
        ready = 1'b1;
        in    = 4'b1111;
        applyStimulus();
        in = 4'b0000;
        checkOutput("post_rst_addressR", 32'(addressR), 32'd0);
        checkOutput("post_rst_pendingR", 32'(pendingR), 32'b1110);
        checkOutput("post_rst_addressF", 32'(addressF), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
